// File: rtl/i2c_target_regs.sv
// I2C target (slave) exposing a byte-addressed register bank.
//   system_clock  : sole clock; SCL/SDA are oversampled on it
//   reset         : synchronous, active-high
//   scl_i, sda_i  : bus lines as seen on the wire (asynchronous)
//   sda_oe        : 1 pulls SDA low (open drain), 0 releases
//   scl_oe        : always 0, no clock stretching
//   wr_strobe     : one-cycle pulse when a data byte is committed
//   wr_index      : register index of the committed byte
//   wr_data       : committed byte value
//   busy          : high from a START until STOP or reset
// Write: START, addr+W, pointer byte, data bytes..., STOP.
// Read : [pointer write], (Sr|START), addr+R, data bytes with ACK, last byte NACK, STOP.
module i2c_target_regs #(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned DEPTH       = 8,
  localparam int unsigned PTR_W      = $clog2(DEPTH)
) (
  input  logic             system_clock,
  input  logic             reset,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic             scl_oe,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_index,
  output logic [7:0]       wr_data,
  output logic             busy
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StWrPtr, StWrData, StWrAck, StRdData, StRdAck, StIgnore
  } state_e;

  state_e           state_q, state_d;
  logic             scl_s1_q, scl_s2_q, scl_prev_q;
  logic             sda_s1_q, sda_s2_q, sda_prev_q;
  logic [2:0]       cnt_q, cnt_d;
  logic [6:0]       shift_q, shift_d;
  logic [6:0]       tx_q, tx_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             rw_q, rw_d;
  // Second half of an ACK slot (ADDR_ACK / WR_ACK) or ACK seen (RD_ACK)
  logic             ack_on_q, ack_on_d;
  logic             sda_oe_q, sda_oe_d;
  logic             wr_strobe_q, wr_strobe_d;
  logic [PTR_W-1:0] wr_index_q, wr_index_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             reg_we;
  logic [7:0]       regs_q [DEPTH];

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  assign scl_rise  = scl_s2_q & ~scl_prev_q;
  assign scl_fall  = ~scl_s2_q & scl_prev_q;
  assign start_det = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;
  // Byte as it will stand once the bit on this SCL rise is shifted in
  assign rx_byte   = {shift_q, sda_s2_q};

  always_ff @(posedge system_clock) begin
    if (reset) begin
      scl_s1_q    <= 1'b1;
      scl_s2_q    <= 1'b1;
      scl_prev_q  <= 1'b1;
      sda_s1_q    <= 1'b1;
      sda_s2_q    <= 1'b1;
      sda_prev_q  <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      ack_on_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_index_q  <= '0;
      wr_data_q   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= 8'h00;
    end else begin
      scl_s1_q    <= scl_i;
      scl_s2_q    <= scl_s1_q;
      scl_prev_q  <= scl_s2_q;
      sda_s1_q    <= sda_i;
      sda_s2_q    <= sda_s1_q;
      sda_prev_q  <= sda_s2_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      ack_on_q    <= ack_on_d;
      sda_oe_q    <= sda_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_index_q  <= wr_index_d;
      wr_data_q   <= wr_data_d;
      if (reg_we) regs_q[ptr_q] <= rx_byte;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    ack_on_d    = ack_on_q;
    sda_oe_d    = sda_oe_q;
    wr_strobe_d = 1'b0;
    wr_index_d  = wr_index_q;
    wr_data_d   = wr_data_q;
    reg_we      = 1'b0;
    if (start_det) begin
      state_d  = StAddr;
      cnt_d    = '0;
      ack_on_d = 1'b0;
      sda_oe_d = 1'b0;
    end else if (stop_det) begin
      state_d  = StIdle;
      ack_on_d = 1'b0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        StAddr, StWrPtr, StWrData: begin
          if (scl_rise) begin
            shift_d = rx_byte[6:0];
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              ack_on_d = 1'b0;
              if (state_q == StAddr) begin
                rw_d    = rx_byte[0];
                state_d = (rx_byte[7:1] == TARGET_ADDR) ? StAddrAck : StIgnore;
              end else if (state_q == StWrPtr) begin
                ptr_d   = rx_byte[PTR_W-1:0];
                state_d = StWrAck;
              end else begin
                reg_we      = 1'b1;
                wr_strobe_d = 1'b1;
                wr_index_d  = ptr_q;
                wr_data_d   = rx_byte;
                ptr_d       = ptr_q + PTR_W'(1);
                state_d     = StWrAck;
              end
            end
          end
        end
        StAddrAck, StWrAck: begin
          if (scl_fall) begin
            if (!ack_on_q) begin
              sda_oe_d = 1'b1;
              ack_on_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              ack_on_d = 1'b0;
              cnt_d    = '0;
              if (state_q == StWrAck) begin
                state_d = StWrData;
              end else if (rw_q) begin
                // Bit 7 goes out on the same fall that ends the ACK
                tx_d     = regs_q[ptr_q][6:0];
                sda_oe_d = ~regs_q[ptr_q][7];
                state_d  = StRdData;
              end else begin
                state_d = StWrPtr;
              end
            end
          end
        end
        StRdData: begin
          if (scl_fall) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              sda_oe_d = 1'b0;
              ack_on_d = 1'b0;
              state_d  = StRdAck;
            end else begin
              sda_oe_d = ~tx_q[6];
              tx_d     = {tx_q[5:0], 1'b0};
            end
          end
        end
        StRdAck: begin
          if (scl_rise && !ack_on_q) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (sda_s2_q) state_d = StIgnore;
            else          ack_on_d = 1'b1;
          end else if (scl_fall && ack_on_q) begin
            tx_d     = regs_q[ptr_q][6:0];
            sda_oe_d = ~regs_q[ptr_q][7];
            cnt_d    = '0;
            ack_on_d = 1'b0;
            state_d  = StRdData;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != StIdle);
    scl_oe    = 1'b0;
    sda_oe    = sda_oe_q;
    wr_strobe = wr_strobe_q;
    wr_index  = wr_index_q;
    wr_data   = wr_data_q;
  end

endmodule
